// File: rtl/wr_fifo_pkg.sv
// Shared constants and helpers for the write-side FIFO stream packer.
// Holds the lane-index width function, the legal-ratio check and the
// default pad value used for the unused lanes of a short final word.
package wr_fifo_pkg;

    // Smallest and largest supported beats-per-word ratios.
    localparam int c_MIN_RATIO = 2;
    localparam int c_MAX_RATIO = 64;

    // Default fill for unused lanes of a short (in_last-terminated) word.
    localparam int c_DEFAULT_PAD = 0;

    // Ceiling log2, used to size the lane index (value >= 2 in practice).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A ratio is legal when it is a power of two within the supported range.
    function automatic bit ratio_is_legal(input int ratio);
        return (ratio >= c_MIN_RATIO) && (ratio <= c_MAX_RATIO) &&
               ((ratio & (ratio - 1)) == 0);
    endfunction

endpackage

// File: rtl/wr_fifo_out_slot.sv
// Single-entry output register in front of a FIFO write port.
//
// Handshake: a word is offered on wr_data while wr_en is high and moves to
// the FIFO on any cycle with wr_en & wr_vld; wr_data/wr_en are registered
// and stay stable until that happens. space tells the producer a load may
// be issued this cycle (slot empty, or draining right now), so a load in
// the same cycle as a drain refills the slot with no bubble.
module wr_fifo_out_slot #(
    parameter int c_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [c_WIDTH-1:0] load_data,
    input  logic               wr_vld,
    output logic               space,
    output logic [c_WIDTH-1:0] wr_data,
    output logic               wr_en
);

    logic               out_full;
    logic [c_WIDTH-1:0] out_q;

    // Slot register: load wins over drain so a simultaneous pair keeps it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_full <= 1'b0;
            out_q    <= '0;
        end else if (load) begin
            out_q    <= load_data;
            out_full <= 1'b1;
        end else if (out_full && wr_vld) begin
            out_full <= 1'b0;
        end
    end

    assign space   = ~out_full | wr_vld;
    assign wr_en   = out_full;
    assign wr_data = out_q;

endmodule

// File: rtl/wr_fifo_stream_packer.sv
// Narrow-to-wide stream packer feeding the write port of the write-side
// prefetch FIFO. Collects c_RATIO input beats into one output word, least
// significant lane first; in_last closes a word early and the lanes above
// the last live beat are filled with c_PAD_VALUE.
//
// Optional feature: define WR_FIFO_PACKER_STATS_EN to add the saturating
// counters stat_words (words written) and stat_pad_words (written words
// that carry at least one pad lane).
//
// Handshake: an input beat is taken on in_valid & in_ready; in_ready is
// combinational (~out_full | wr_vld). A packed word moves to the FIFO on
// wr_en & wr_vld and is held stable while wr_en & ~wr_vld.
module wr_fifo_stream_packer
    import wr_fifo_pkg::*;
#(
    parameter int                    c_IN_WIDTH  = 8,
    parameter int                    c_OUT_WIDTH = 32,
    parameter logic [c_IN_WIDTH-1:0] c_PAD_VALUE = c_IN_WIDTH'(c_DEFAULT_PAD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [c_IN_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [c_OUT_WIDTH-1:0] wr_data,
    output logic                   wr_en,
    input  logic                   wr_vld
`ifdef WR_FIFO_PACKER_STATS_EN
    ,
    output logic [31:0]            stat_words,
    output logic [31:0]            stat_pad_words
`endif
);

    localparam int c_RATIO = c_OUT_WIDTH / c_IN_WIDTH;
    localparam int c_IDX_W = clog2(c_RATIO);
    localparam bit c_CFG_OK = ratio_is_legal(c_RATIO) &&
                              (c_RATIO * c_IN_WIDTH == c_OUT_WIDTH);

    generate
        if (!c_CFG_OK) begin : g_bad_cfg
            $error("wr_fifo_stream_packer: unsupported width ratio");
        end
    endgenerate

    logic [c_RATIO-1:0][c_IN_WIDTH-1:0] asm_q;
    logic [c_RATIO-1:0][c_IN_WIDTH-1:0] close_word;
    logic [c_IDX_W-1:0]                 idx;
    logic                               accept;
    logic                               last_lane;
    logic                               closing;
    logic                               space;

    assign accept    = in_valid & in_ready;
    assign last_lane = (idx == c_IDX_W'(c_RATIO - 1));
    assign closing   = accept & (in_last | last_lane);
    assign in_ready  = space;

    // Word as it leaves on a closing beat: stored lanes below idx, the
    // incoming beat at idx, pad above it.
    always_comb begin
        close_word = '0;
        for (int l = 0; l < c_RATIO; l++) begin
            if (l < int'(idx)) begin
                close_word[l] = asm_q[l];
            end else if (l == int'(idx)) begin
                close_word[l] = in_data;
            end else begin
                close_word[l] = c_PAD_VALUE;
            end
        end
    end

    // Lane assembly: store each accepted beat and advance or wrap the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
            idx   <= '0;
        end else if (accept) begin
            asm_q[idx] <= in_data;
            if (closing) begin
                idx <= '0;
            end else begin
                idx <= idx + c_IDX_W'(1);
            end
        end
    end

    wr_fifo_out_slot #(
        .c_WIDTH(c_OUT_WIDTH)
    ) u_out_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (closing),
        .load_data(close_word),
        .wr_vld   (wr_vld),
        .space    (space),
        .wr_data  (wr_data),
        .wr_en    (wr_en)
    );

`ifdef WR_FIFO_PACKER_STATS_EN
    logic pad_q;
    logic xfer;

    assign xfer = wr_en & wr_vld;

    // Remember whether the word now in the slot was closed short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_q <= 1'b0;
        end else if (closing) begin
            pad_q <= ~last_lane;
        end
    end

    // Saturating counters of words written and padded words written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words     <= '0;
            stat_pad_words <= '0;
        end else if (xfer) begin
            if (stat_words != 32'hFFFF_FFFF) begin
                stat_words <= stat_words + 32'd1;
            end
            if (pad_q && (stat_pad_words != 32'hFFFF_FFFF)) begin
                stat_pad_words <= stat_pad_words + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wr_fifo_stream_packer.sv
// Bench for wr_fifo_stream_packer (8-bit beats into 32-bit words).
module tb_wr_fifo_stream_packer;

    localparam int c_IN_WIDTH  = 8;
    localparam int c_OUT_WIDTH = 32;
    localparam int c_RATIO     = 4;
    localparam logic [7:0] c_PAD = 8'h00;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_vld = 1'b0;
`ifdef WR_FIFO_PACKER_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_pad_words;
`endif

    wr_fifo_stream_packer #(
        .c_IN_WIDTH (c_IN_WIDTH),
        .c_OUT_WIDTH(c_OUT_WIDTH),
        .c_PAD_VALUE(c_PAD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_last (in_last),
        .in_ready(in_ready),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .wr_vld  (wr_vld)
`ifdef WR_FIFO_PACKER_STATS_EN
        ,
        .stat_words    (stat_words),
        .stat_pad_words(stat_pad_words)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad = 0;
    logic [c_OUT_WIDTH-1:0] exp_q[$];   // words owed to the FIFO, oldest first
    bit                     exp_pad_q[$];
    logic [7:0]             cur_q[$];   // beats of the word being collected
    int                     model_words = 0;
    int                     model_pads = 0;
    int                     acc_cnt = 0;
    logic [31:0]            xfer_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_pad_q.delete();
        cur_q.delete();
    endtask

    // One clock: drive at negedge, check outputs against the model, then
    // advance the model by what the coming posedge must do.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit wv,
                        output bit s_rdy, output bit s_en, output logic [31:0] s_data);
        bit rdy_exp;
        logic [31:0] w;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        wr_vld   = wv;
        #1;
        s_rdy  = in_ready;
        s_en   = wr_en;
        s_data = wr_data;
        rdy_exp = (exp_q.size() == 0) || wv;
        check("in_ready", in_ready, rdy_exp);
        check("wr_en", wr_en, exp_q.size() != 0);
        if (exp_q.size() != 0) check("wr_data", wr_data, exp_q[0]);
        if (v && in_ready) acc_cnt++;
        if (wr_en && wv) xfer_log.push_back(wr_data);
        if (exp_q.size() != 0 && wv) begin
            void'(exp_q.pop_front());
            if (exp_pad_q.pop_front()) model_pads++;
            model_words++;
        end
        if (v && rdy_exp) begin
            cur_q.push_back(d);
            if (l || cur_q.size() == c_RATIO) begin
                w = '0;
                for (int i = 0; i < c_RATIO; i++) begin
                    w[i*8 +: 8] = (i < cur_q.size()) ? cur_q[i] : c_PAD;
                end
                exp_q.push_back(w);
                exp_pad_q.push_back(cur_q.size() < c_RATIO);
                cur_q.delete();
            end
        end
    endtask

    task automatic idle(input int n, input bit wv);
        bit r, e;
        logic [31:0] dd;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, wv, r, e, dd);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          l;
        bit          wv;
        bit          rdy;
        bit          en;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit          r, e;
        logic [31:0] dd;
        logic [7:0]  src_q[$];
        logic [31:0] want[$];
        int          n_words;

        // Continuous bytes, short packet, single-beat packet, drain+close overlap.
        tbl[0]  = '{1, 8'h11, 0, 1, 1, 0, 32'h0};
        tbl[1]  = '{1, 8'h22, 0, 1, 1, 0, 32'h0};
        tbl[2]  = '{1, 8'h33, 0, 1, 1, 0, 32'h0};
        tbl[3]  = '{1, 8'h44, 0, 1, 1, 0, 32'h0};
        tbl[4]  = '{1, 8'h55, 0, 1, 1, 1, 32'h44332211};
        tbl[5]  = '{1, 8'h66, 0, 1, 1, 0, 32'h0};
        tbl[6]  = '{1, 8'h77, 0, 1, 1, 0, 32'h0};
        tbl[7]  = '{1, 8'h88, 0, 1, 1, 0, 32'h0};
        tbl[8]  = '{1, 8'hA1, 0, 1, 1, 1, 32'h88776655};
        tbl[9]  = '{1, 8'hA2, 1, 1, 1, 0, 32'h0};
        tbl[10] = '{1, 8'h5C, 1, 1, 1, 1, 32'h0000A2A1};
        tbl[11] = '{0, 8'h00, 0, 1, 1, 1, 32'h0000005C};
        tbl[12] = '{0, 8'h00, 0, 1, 1, 0, 32'h0};

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].wv, r, e, dd);
            check($sformatf("tbl%0d_in_ready", i), r, tbl[i].rdy);
            check($sformatf("tbl%0d_wr_en", i), e, tbl[i].en);
            if (tbl[i].en) check($sformatf("tbl%0d_wr_data", i), dd, tbl[i].data);
        end
`ifdef WR_FIFO_PACKER_STATS_EN
        check("stat_words_tbl", stat_words, 32'd4);
        check("stat_pad_tbl", stat_pad_words, 32'd2);
`endif

        // Full FIFO stall: 10 clocks of wr_vld=0 while 12 bytes are offered.
        for (int i = 1; i <= 12; i++) src_q.push_back(8'(i));
        acc_cnt = 0;
        xfer_log.delete();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, src_q[0], 1'b0, 1'b0, r, e, dd);
            if (r) void'(src_q.pop_front());
        end
        check("stall_accepted", acc_cnt, 4);
        check("stall_in_ready", r, 1'b0);
        check("stall_wr_data_held", dd, 32'h04030201);
        for (int c = 0; c < 40 && src_q.size() != 0; c++) begin
            step(1'b1, src_q[0], 1'b0, 1'b1, r, e, dd);
            if (r) void'(src_q.pop_front());
        end
        check("stall_src_drained", src_q.size(), 0);
        idle(3, 1'b1);
        want = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        check("stall_word_count", xfer_log.size(), 3);
        for (int i = 0; i < 3 && i < xfer_log.size(); i++)
            check($sformatf("stall_word%0d", i), xfer_log[i], want[i]);

        // Back-to-back: 40 beats at full rate give 10 words, no gaps.
        xfer_log.delete();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1, r, e, dd);
            if (i >= 4) check("b2b_wr_en", e, (i % 4) == 0);
        end
        idle(2, 1'b1);
        n_words = xfer_log.size();
        check("b2b_word_count", n_words, 10);

        // Reset with a pending word and a stalled beat.
        for (int i = 0; i < 4; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, r, e, dd);
        step(1'b1, 8'hEE, 1'b0, 1'b0, r, e, dd);
        check("pending_before_reset", e, 1'b1);
        in_valid = 1'b0;
        async_reset();
        // Reset mid-word after two bytes; post-reset word must be clean.
        step(1'b1, 8'hD1, 1'b0, 1'b1, r, e, dd);
        step(1'b1, 8'hD2, 1'b0, 1'b1, r, e, dd);
        in_valid = 1'b0;
        async_reset();
        xfer_log.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b1, r, e, dd);
        idle(2, 1'b1);
        check("post_reset_count", xfer_log.size(), 1);
        if (xfer_log.size() != 0) check("post_reset_word", xfer_log[0], 32'hC4C3C2C1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, r, e, dd);
        end
        idle(4, 1'b1);
        check("final_queue_empty", exp_q.size(), 0);
`ifdef WR_FIFO_PACKER_STATS_EN
        check("stat_words", stat_words, 32'(model_words));
        check("stat_pad_words", stat_pad_words, 32'(model_pads));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
